// File: rtl/xg_frame_wr_if.sv
`default_nettype none
// ============================================================================
//  Module      : xg_frame_wr_if
//  Description : Source byte stream and FIFO write-port bundle for
//                xg_frame_wr. The slave modport is the frame writer's view;
//                the master modport is the surrounding source/FIFO view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface xg_frame_wr_if #(
  parameter int DW = 8
);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic [DW+1:0] fifo_wdata;
  logic          fifo_winc;
  logic          fifo_wfull;
  logic          fifo_w_almost_full;

  modport slave (
    input  s_valid, s_data, s_last, fifo_wfull, fifo_w_almost_full,
    output s_ready, fifo_wdata, fifo_winc
  );

  modport master (
    output s_valid, s_data, s_last, fifo_wfull, fifo_w_almost_full,
    input  s_ready, fifo_wdata, fifo_winc
  );
endinterface
`default_nettype wire

// File: rtl/xg_frame_wr.sv
`default_nettype none
// ============================================================================
//  Module      : xg_frame_wr
//  Description : Frames a source byte stream into FIFO entries {err,last,byte}.
//                Short frames are padded up to MIN_LEN, long frames are cut at
//                MAX_LEN (flagged err) and the rest of the frame is dropped.
//                A single output register decouples the source from the FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module xg_frame_wr #(
  parameter int              DW       = 8,
  parameter int              LEN_W    = 11,
  parameter int              MIN_LEN  = 60,
  parameter int              MAX_LEN  = 1518,
  parameter logic [DW-1:0]   PAD_BYTE = 8'h00
) (
  input  wire logic          wclk,
  input  wire logic          wrst_n,
  input  wire logic          en,
  xg_frame_wr_if.slave       bus,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        trunc_cnt,
  output logic               busy
);

  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DATA    = 2'd1,
    S_PAD     = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              ovalid_q, ovalid_d;
  logic [DW+1:0]     odata_q, odata_d;
  logic [15:0]       frame_cnt_q, trunc_cnt_q;
  logic              frame_inc, trunc_inc;
  logic              load_ok, xfer, s_ready_w;
  logic [LEN_W-1:0]  len_inc;

  // The output register may take a new entry when empty or draining now.
  assign load_ok        = ~ovalid_q | ~bus.fifo_wfull;
  assign bus.fifo_winc  = ovalid_q & ~bus.fifo_wfull;
  assign bus.fifo_wdata = odata_q;
  assign bus.s_ready    = s_ready_w;
  assign xfer           = bus.s_valid & s_ready_w;
  // Length the frame will have once the entry loaded this cycle is counted.
  assign len_inc        = (state_q == S_IDLE) ? LEN_W'(1) : len_q + LEN_W'(1);

  assign frame_cnt = frame_cnt_q;
  assign trunc_cnt = trunc_cnt_q;
  assign busy      = (state_q != S_IDLE) | ovalid_q;

  // Next-state, output-register load and source handshake.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    ovalid_d  = ovalid_q & bus.fifo_wfull;
    odata_d   = odata_q;
    frame_inc = 1'b0;
    trunc_inc = 1'b0;
    s_ready_w = 1'b0;

    case (state_q)
      // wrst_n gate keeps s_ready low while reset is held.
      S_IDLE:    s_ready_w = wrst_n & en & ~bus.fifo_w_almost_full & load_ok;
      S_DATA:    s_ready_w = load_ok;
      S_PAD:     s_ready_w = 1'b0;
      S_DISCARD: s_ready_w = 1'b1;
      default:   s_ready_w = 1'b0;
    endcase

    if (xfer && (state_q == S_IDLE || state_q == S_DATA)) begin
      ovalid_d = 1'b1;
      len_d    = len_inc;
      if (bus.s_last) begin
        // A last byte landing exactly on MAX_LEN is a normal completion.
        if (len_inc >= MIN_L) begin
          odata_d   = {1'b0, 1'b1, bus.s_data};
          frame_inc = 1'b1;
          state_d   = S_IDLE;
        end else begin
          odata_d   = {1'b0, 1'b0, bus.s_data};
          state_d   = S_PAD;
        end
      end else if (len_inc == MAX_L) begin
        odata_d   = {1'b1, 1'b1, bus.s_data};
        frame_inc = 1'b1;
        trunc_inc = 1'b1;
        state_d   = S_DISCARD;
      end else begin
        odata_d   = {1'b0, 1'b0, bus.s_data};
        state_d   = S_DATA;
      end
    end

    if (state_q == S_PAD && load_ok) begin
      ovalid_d = 1'b1;
      len_d    = len_inc;
      odata_d  = {1'b0, (len_inc == MIN_L), PAD_BYTE};
      if (len_inc == MIN_L) begin
        frame_inc = 1'b1;
        state_d   = S_IDLE;
      end
    end

    if (state_q == S_DISCARD && xfer && bus.s_last) begin
      state_d = S_IDLE;
    end
  end

  // State, length, output register and counters.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      ovalid_q    <= 1'b0;
      odata_q     <= '0;
      frame_cnt_q <= '0;
      trunc_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
      if (frame_inc) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (trunc_inc) trunc_cnt_q <= trunc_cnt_q + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xg_frame_wr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xg_frame_wr
//  Description : Self-checking bench for xg_frame_wr. A queue model turns each
//                accepted source byte into the FIFO entries it must produce;
//                one negedge process compares every FIFO write against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xg_frame_wr;
  localparam int         MIN_LEN = 60;
  localparam int         MAX_LEN = 1518;
  localparam logic [7:0] PAD     = 8'h00;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic        en;
  logic [15:0] frame_cnt, trunc_cnt;
  logic        busy;

  xg_frame_wr_if #(.DW(8)) bus ();

  xg_frame_wr #(
    .DW(8), .LEN_W(11), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .PAD_BYTE(PAD)
  ) dut (
    .wclk(wclk), .wrst_n(wrst_n), .en(en), .bus(bus),
    .frame_cnt(frame_cnt), .trunc_cnt(trunc_cnt), .busy(busy)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;
  int stalls = 0;
  bit rnd_full = 1'b0;

  // Model state
  logic [9:0] exp_q[$];
  int         m_idx = 0;
  bit         m_disc = 1'b0;
  int         m_frames = 0;
  int         m_truncs = 0;
  int         n_wr = 0, n_last = 0, n_err = 0;
  logic [9:0] last_ent = '0;
  logic [9:0] err_ent = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected FIFO entries for one accepted source byte.
  task automatic model_byte(input logic [7:0] b, input logic l);
    if (m_disc) begin
      if (l) m_disc = 1'b0;
      return;
    end
    m_idx++;
    if (l) begin
      if (m_idx >= MIN_LEN) begin
        exp_q.push_back({2'b01, b});
      end else begin
        exp_q.push_back({2'b00, b});
        for (int k = m_idx + 1; k <= MIN_LEN; k++)
          exp_q.push_back({1'b0, (k == MIN_LEN), PAD});
      end
      m_frames++;
      m_idx = 0;
    end else if (m_idx == MAX_LEN) begin
      exp_q.push_back({2'b11, b});
      m_frames++;
      m_truncs++;
      m_disc = 1'b1;
      m_idx = 0;
    end else begin
      exp_q.push_back({2'b00, b});
    end
  endtask

  // Compare process: every FIFO write against the model, then update model.
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge wclk);
      if (!wrst_n) begin
        exp_q.delete();
        m_idx = 0; m_disc = 1'b0; m_frames = 0; m_truncs = 0;
      end else begin
        if (bus.fifo_winc) begin
          chk("winc_while_full", {31'd0, bus.fifo_wfull}, 32'd0);
          n_wr++;
          if (bus.fifo_wdata[8]) begin n_last++; last_ent = bus.fifo_wdata; end
          if (bus.fifo_wdata[9]) begin n_err++;  err_ent  = bus.fifo_wdata; end
          if (exp_q.size() == 0) begin
            chk("unexpected_write", {22'd0, bus.fifo_wdata}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("fifo_entry", {22'd0, bus.fifo_wdata}, {22'd0, e});
          end
        end
        if (bus.s_valid && bus.s_ready) model_byte(bus.s_data, bus.s_last);
      end
    end
  end

  // FIFO full generator: random while rnd_full is set, otherwise clear.
  initial begin
    bus.fifo_wfull = 1'b0;
    forever begin
      @(posedge wclk); #1;
      bus.fifo_wfull = rnd_full ? ($urandom_range(0, 99) < 40) : 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    bit acc;
    int t;
    acc = 1'b0; t = 0;
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = l;
    while (!acc && t < 2000) begin
      @(negedge wclk);
      acc = bus.s_ready;
      if (!acc) stalls++;
      @(posedge wclk); #1;
      t++;
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input int n, input int base);
    for (int i = 0; i < n; i++) send_byte(8'((base + i) & 8'hFF), (i == n - 1));
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin @(negedge wclk); t++; end while (busy && t < 5000);
    chk("idle_timeout", {31'd0, busy}, 32'd0);
    @(posedge wclk); #1;
  endtask

  initial begin
    int wr0, last0, err0, st0, bad;
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0, last0, err0, st0, bad;
    wrst_n = 1'b0; en = 1'b1;
    bus.s_valid = 1'b1; bus.s_data = 8'hA5; bus.s_last = 1'b0;
    bus.fifo_w_almost_full = 1'b0;

    // Reset values
    @(negedge wclk);
    chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd0);
    chk("rst_winc", {31'd0, bus.fifo_winc}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wdata", {22'd0, bus.fifo_wdata}, 32'd0);
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    @(posedge wclk); #1;
    bus.s_valid = 1'b0; wrst_n = 1'b1;
    @(posedge wclk); #1;

    // 64-byte frame, no backpressure
    wr0 = n_wr; last0 = n_last; st0 = stalls;
    send_frame(64, 0);
    wait_idle();
    chk("t1_writes", n_wr - wr0, 64);
    chk("t1_lasts", n_last - last0, 1);
    chk("t1_last_entry", {22'd0, last_ent}, 32'h13F);
    chk("t1_stalls", stalls - st0, 0);
    chk("t1_frame_cnt", {16'd0, frame_cnt}, 32'd1);

    // 10-byte frame, padded to 60
    wr0 = n_wr; last0 = n_last;
    send_frame(10, 8'h80);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge wclk);
      if (bus.s_ready !== 1'b0) bad++;
    end
    chk("t2_sready_pad", bad, 0);
    @(negedge wclk);
    chk("t2_sready_after", {31'd0, bus.s_ready}, 32'd1);
    @(posedge wclk); #1;
    wait_idle();
    chk("t2_writes", n_wr - wr0, 60);
    chk("t2_lasts", n_last - last0, 1);
    chk("t2_last_entry", {22'd0, last_ent}, {24'd1, PAD});
    chk("t2_frame_cnt", {16'd0, frame_cnt}, 32'd2);

    // 1600-byte frame, truncated at 1518
    wr0 = n_wr; last0 = n_last; err0 = n_err; st0 = stalls;
    send_frame(1600, 0);
    wait_idle();
    chk("t3_writes", n_wr - wr0, MAX_LEN);
    chk("t3_errs", n_err - err0, 1);
    chk("t3_lasts", n_last - last0, 1);
    chk("t3_err_entry", {22'd0, err_ent}, 32'h3ED);
    chk("t3_stalls", stalls - st0, 0);
    chk("t3_trunc_cnt", {16'd0, trunc_cnt}, 32'd1);
    chk("t3_frame_cnt", {16'd0, frame_cnt}, 32'd3);

    // 100-byte frame under random FIFO full
    wr0 = n_wr;
    rnd_full = 1'b1;
    send_frame(100, 8'h10);
    rnd_full = 1'b0;
    wait_idle();
    chk("t4_writes", n_wr - wr0, 100);
    chk("t4_frame_cnt", {16'd0, frame_cnt}, 32'd4);

    // almost_full holds off a frame start, but not a frame in progress
    bus.fifo_w_almost_full = 1'b1;
    bus.s_valid = 1'b1; bus.s_data = 8'h40; bus.s_last = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge wclk);
      if (bus.s_ready !== 1'b0 || bus.fifo_winc !== 1'b0) bad++;
    end
    chk("t5_af_hold", bad, 0);
    @(posedge wclk); #1;
    bus.fifo_w_almost_full = 1'b0;
    wr0 = n_wr; st0 = stalls;
    for (int i = 0; i < 70; i++) begin
      if (i == 5)  bus.fifo_w_almost_full = 1'b1;
      if (i == 10) en = 1'b0;
      send_byte(8'(8'h40 + i), (i == 69));
    end
    chk("t5_stalls", stalls - st0, 0);
    bus.fifo_w_almost_full = 1'b0; en = 1'b1;
    wait_idle();
    chk("t5_writes", n_wr - wr0, 70);
    chk("t5_frame_cnt", {16'd0, frame_cnt}, 32'd5);

    // Reset mid-frame, then a clean frame
    for (int i = 0; i < 20; i++) send_byte(8'(8'hC0 + i), 1'b0);
    bus.s_valid = 1'b1; bus.s_data = 8'hEE;
    wrst_n = 1'b0;
    @(negedge wclk);
    chk("t6_s_ready", {31'd0, bus.s_ready}, 32'd0);
    chk("t6_winc", {31'd0, bus.fifo_winc}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_wdata", {22'd0, bus.fifo_wdata}, 32'd0);
    chk("t6_counts", {frame_cnt, trunc_cnt}, 32'd0);
    @(posedge wclk); #1;
    bus.s_valid = 1'b0;
    @(posedge wclk); #1;
    wrst_n = 1'b1;
    @(posedge wclk); #1;
    wr0 = n_wr;
    send_frame(64, 8'h20);
    wait_idle();
    chk("t6_writes", n_wr - wr0, 64);
    chk("t6_frame_cnt", {16'd0, frame_cnt}, 32'd1);
    chk("model_frames", {16'd0, frame_cnt}, m_frames);
    chk("model_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
